// File: rtl/phase_pair_generator_pkg.sv
// Shared types for the two-channel phase-offset square-wave source.
// State encoding, default field widths and the captured configuration record.
package phase_gen_pkg;

   localparam int PG_CNT_W = 32;
   localparam int PG_CYC_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } pg_state_e;

   typedef struct packed {
      logic [PG_CNT_W-1:0] period;
      logic [PG_CNT_W-1:0] high;
      logic [PG_CNT_W-1:0] phase;
      logic [PG_CYC_W-1:0] cycles;
   } pg_cfg_t;

   // A config is usable only if both channels can show a non-empty, non-full high phase
   // and the CHB lag fits inside one period.
   function automatic logic cfg_is_valid(input pg_cfg_t c);
      return (c.period >= PG_CNT_W'(2)) && (c.high != '0) &&
             (c.high < c.period) && (c.phase < c.period);
   endfunction

endpackage

// File: rtl/phase_pair_generator_if.sv
// Config handshake, stop request and waveform/status outputs of the phase pair generator.
// master drives config and stop; slave is the generator.
interface phase_pair_generator_if
   import phase_gen_pkg::*;
#(
   parameter int CNT_W = PG_CNT_W,
   parameter int CYC_W = PG_CYC_W
);
   logic             cfgValid;
   logic             cfgReady;
   logic [CNT_W-1:0] cfgPeriod;
   logic [CNT_W-1:0] cfgHigh;
   logic [CNT_W-1:0] cfgPhase;
   logic [CYC_W-1:0] cfgCycles;
   logic             stop;
   logic             CHA;
   logic             CHB;
   logic             running;
   logic             done;
   logic             cfgErr;

   modport master (
      output cfgValid, cfgPeriod, cfgHigh, cfgPhase, cfgCycles, stop,
      input  cfgReady, CHA, CHB, running, done, cfgErr
   );

   modport slave (
      input  cfgValid, cfgPeriod, cfgHigh, cfgPhase, cfgCycles, stop,
      output cfgReady, CHA, CHB, running, done, cfgErr
   );

endinterface

// File: rtl/phase_pair_generator_counter.sv
// Loadable modulo-period counter with a combinational wrap flag and a "count < high" compare.
// Zero-latency flags from the current count; load has priority over enable, no backpressure.
module mod_period_counter
   import phase_gen_pkg::*;
#(
   parameter int CNT_W = PG_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] high,
   output logic             wrap,
   output logic             lt_high
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign wrap    = (cnt_q == (period - CNT_W'(1)));
   assign lt_high = (cnt_q < high);

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/phase_pair_generator.sv
// Two-channel square-wave source: CHA/CHB share period and high time, CHB lags CHA by a set phase.
// First CHA edge 2 cycles after config accept; config is only accepted in IDLE (cfgReady).
module phase_pair_generator
   import phase_gen_pkg::*;
#(
   parameter int CNT_W = PG_CNT_W,
   parameter int CYC_W = PG_CYC_W
) (
   input  logic                   sysClk,
   input  logic                   sysRst,
   phase_pair_generator_if.slave  io
);

   pg_state_e        state_q, state_d;
   pg_cfg_t          cfg_q, cfg_d;
   logic [CYC_W-1:0] cyc_left_q, cyc_left_d;
   logic             stop_q, stop_d;
   logic             armed_q, armed_d;
   logic             cha_q, cha_d;
   logic             chb_q, chb_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             cfg_ok;
   logic             cnt_load;
   logic             a_en, b_en;
   logic             a_wrap, b_wrap;
   logic             a_lt, b_lt;
   logic [CNT_W-1:0] b_load_val;
   logic             stop_seen;
   logic             last_period;

   assign cfg_ok      = cfg_is_valid(cfg_q);
   assign cnt_load    = (state_q == ST_LOAD) && cfg_ok;
   assign a_en        = (state_q == ST_RUN);
   assign b_en        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign b_load_val  = (cfg_q.phase == '0) ? '0 : (cfg_q.period - cfg_q.phase);
   assign stop_seen   = stop_q || io.stop;
   assign last_period = (cfg_q.cycles != '0) && (cyc_left_q == CYC_W'(1));

   mod_period_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk      (sysClk),
      .rst_n    (sysRst),
      .load     (cnt_load),
      .en       (a_en),
      .load_val ('0),
      .period   (cfg_q.period),
      .high     (cfg_q.high),
      .wrap     (a_wrap),
      .lt_high  (a_lt)
   );

   mod_period_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk      (sysClk),
      .rst_n    (sysRst),
      .load     (cnt_load),
      .en       (b_en),
      .load_val (b_load_val),
      .period   (cfg_q.period),
      .high     (cfg_q.high),
      .wrap     (b_wrap),
      .lt_high  (b_lt)
   );

   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      cyc_left_d = cyc_left_q;
      stop_d     = stop_q;
      armed_d    = armed_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (io.cfgValid) begin
               cfg_d.period = io.cfgPeriod;
               cfg_d.high   = io.cfgHigh;
               cfg_d.phase  = io.cfgPhase;
               cfg_d.cycles = io.cfgCycles;
               state_d      = ST_LOAD;
            end
         end

         ST_LOAD: begin
            stop_d = 1'b0;
            if (!cfg_ok) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cyc_left_d = cfg_q.cycles;
               // CHB stays quiet until counter B first reaches zero, so a lag that lands
               // its start inside the high window cannot emit an early partial pulse.
               armed_d    = (cfg_q.phase == '0);
               state_d    = ST_RUN;
            end
         end

         ST_RUN: begin
            stop_d = stop_seen;
            if (b_wrap) begin
               armed_d = 1'b1;
            end
            if (a_wrap) begin
               stop_d = 1'b0;
               if (cfg_q.cycles != '0) begin
                  cyc_left_d = cyc_left_q - CYC_W'(1);
               end
               if (last_period || stop_seen) begin
                  if (cfg_q.phase == '0) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end
            end
         end

         ST_DRAIN: begin
            if (b_wrap) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Both compares are registered, so each channel lags its counter by exactly one cycle.
   always_comb begin
      cha_d = (state_q == ST_RUN) && a_lt;
      chb_d = b_en && armed_q && b_lt;
   end

   always_ff @(posedge sysClk or negedge sysRst) begin
      if (!sysRst) begin
         state_q    <= ST_IDLE;
         cfg_q      <= '0;
         cyc_left_q <= '0;
         stop_q     <= 1'b0;
         armed_q    <= 1'b0;
         cha_q      <= 1'b0;
         chb_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         cyc_left_q <= cyc_left_d;
         stop_q     <= stop_d;
         armed_q    <= armed_d;
         cha_q      <= cha_d;
         chb_q      <= chb_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign io.cfgReady = (state_q == ST_IDLE);
   assign io.running  = (state_q != ST_IDLE);
   assign io.CHA      = cha_q;
   assign io.CHB      = chb_q;
   assign io.done     = done_q;
   assign io.cfgErr   = err_q;

endmodule
